// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: sequences one dot product per transaction into a
// OneMac-style multiply-accumulate unit. It latches two length-N 8-bit
// operand vectors, clears the MAC, streams one operand pair per clock,
// then captures the MAC sum and offers it on a valid/ready result port.
module mac_operand_feeder #(
    parameter int unsigned N = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [8*N-1:0]   a_vec,
    input  logic [8*N-1:0]   b_vec,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    output logic             mac_reset_n,
    input  logic [19:0]      mac_sum,
    output logic [19:0]      result,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int unsigned   IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        CAPTURE,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] index;
    logic [IW-1:0] index_nxt;
    logic [7:0]    a_mem [N];
    logic [7:0]    b_mem [N];

    // Only used while index < LAST, so it never wraps past N-1.
    assign index_nxt = index + 1'b1;

    // Sequencer: state, operand storage and all registered outputs.
    // Operands are registered one cycle ahead so that mac_a/mac_b carry
    // element i during the cycle that the MAC accumulates element i.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            index        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            load_ready   <= 1'b1;
            mac_reset_n  <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            a_mem[i] <= a_vec[8*i +: 8];
                            b_mem[i] <= b_vec[8*i +: 8];
                        end
                        index       <= '0;
                        mac_a       <= a_vec[7:0];
                        mac_b       <= b_vec[7:0];
                        mac_reset_n <= 1'b1;
                        load_ready  <= 1'b0;
                        state       <= FEED;
                    end
                end
                FEED: begin
                    if (index == LAST) begin
                        // Zero operands freeze the MAC sum for capture.
                        mac_a <= '0;
                        mac_b <= '0;
                        state <= CAPTURE;
                    end else begin
                        index <= index_nxt;
                        mac_a <= a_mem[index_nxt];
                        mac_b <= b_mem[index_nxt];
                    end
                end
                CAPTURE: begin
                    result       <= mac_sum;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        load_ready   <= 1'b1;
                        mac_reset_n  <= 1'b0;
                        index        <= '0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                    load_ready   <= 1'b1;
                    mac_reset_n  <= 1'b0;
                    mac_a        <= '0;
                    mac_b        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder: three feeders (N=4, N=16, N=1),
// each attached to a behavioural OneMac accumulator.
module tb_mac_operand_feeder;

    logic clock;
    logic reset;

    int errors = 0;
    int checks = 0;

    // ---------------- N=4 instance ----------------
    logic        lv4, lr4, mrn4, rv4, rr4, q4;
    logic [31:0] a4, b4;
    logic [7:0]  ma4, mb4;
    logic [19:0] ms4, r4;

    mac_operand_feeder #(.N(4)) u4 (
        .clock(clock), .reset(reset),
        .load_valid(lv4), .load_ready(lr4),
        .a_vec(a4), .b_vec(b4),
        .mac_a(ma4), .mac_b(mb4), .mac_reset_n(mrn4),
        .mac_sum(ms4),
        .result(r4), .result_valid(rv4), .result_ready(rr4)
    );

    // OneMac model: reset input registered; accumulate restarts from 0
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q4  <= 1'b0;
            ms4 <= '0;
        end else begin
            q4  <= mrn4;
            ms4 <= (q4 ? ms4 : 20'd0) + 20'(ma4) * 20'(mb4);
        end
    end

    // ---------------- N=16 instance ----------------
    logic         lv16, lr16, mrn16, rv16, rr16, q16;
    logic [127:0] a16, b16;
    logic [7:0]   ma16, mb16;
    logic [19:0]  ms16, r16;

    mac_operand_feeder #(.N(16)) u16 (
        .clock(clock), .reset(reset),
        .load_valid(lv16), .load_ready(lr16),
        .a_vec(a16), .b_vec(b16),
        .mac_a(ma16), .mac_b(mb16), .mac_reset_n(mrn16),
        .mac_sum(ms16),
        .result(r16), .result_valid(rv16), .result_ready(rr16)
    );

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q16  <= 1'b0;
            ms16 <= '0;
        end else begin
            q16  <= mrn16;
            ms16 <= (q16 ? ms16 : 20'd0) + 20'(ma16) * 20'(mb16);
        end
    end

    // ---------------- N=1 instance ----------------
    logic        lv1, lr1, mrn1, rv1, rr1, q1;
    logic [7:0]  a1, b1;
    logic [7:0]  ma1, mb1;
    logic [19:0] ms1, r1;

    mac_operand_feeder #(.N(1)) u1 (
        .clock(clock), .reset(reset),
        .load_valid(lv1), .load_ready(lr1),
        .a_vec(a1), .b_vec(b1),
        .mac_a(ma1), .mac_b(mb1), .mac_reset_n(mrn1),
        .mac_sum(ms1),
        .result(r1), .result_valid(rv1), .result_ready(rr1)
    );

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q1  <= 1'b0;
            ms1 <= '0;
        end else begin
            q1  <= mrn1;
            ms1 <= (q1 ? ms1 : 20'd0) + 20'(ma1) * 20'(mb1);
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One N=4 transaction up to DONE; optionally pulses load_valid with
    // other vectors during FEED. Leaves result_ready low.
    task automatic tx4(input logic [31:0] a, input logic [31:0] b,
                       input logic [19:0] exp, input bit poke, input string tag);
        @(negedge clock);
        a4 = a; b4 = b; lv4 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        lv4 = 1'b0;
        check({tag, ".lr_busy"}, 32'(lr4), 32'd0);
        check({tag, ".ma0"}, 32'(ma4), 32'(a[7:0]));
        check({tag, ".mrn"}, 32'(mrn4), 32'd1);
        for (int m = 1; m <= 5; m++) begin
            @(negedge clock);
            if (poke && m < 3) begin
                lv4 = 1'b1; a4 = 32'h09090909; b4 = 32'h07070707;
            end else begin
                lv4 = 1'b0;
            end
            if (m == 4) check({tag, ".rv_early"}, 32'(rv4), 32'd0);
            if (m == 5) begin
                check({tag, ".rv"}, 32'(rv4), 32'd1);
                check({tag, ".result"}, 32'(r4), 32'(exp));
                check({tag, ".ma_done"}, 32'(ma4), 32'd0);
                check({tag, ".mb_done"}, 32'(mb4), 32'd0);
            end
        end
    endtask

    task automatic release4(input string tag);
        @(negedge clock);
        rr4 = 1'b1;
        @(negedge clock);
        rr4 = 1'b0;
        check({tag, ".rv_clr"}, 32'(rv4), 32'd0);
        check({tag, ".lr_idle"}, 32'(lr4), 32'd1);
        check({tag, ".mrn_idle"}, 32'(mrn4), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        lv4 = 0; rr4 = 0; a4 = '0; b4 = '0;
        lv16 = 0; rr16 = 0; a16 = '0; b16 = '0;
        lv1 = 0; rr1 = 0; a1 = '0; b1 = '0;

        // Reset state
        #12;
        check("rst.lr", 32'(lr4), 32'd1);
        check("rst.mrn", 32'(mrn4), 32'd0);
        check("rst.ma", 32'(ma4), 32'd0);
        check("rst.mb", 32'(mb4), 32'd0);
        check("rst.rv", 32'(rv4), 32'd0);
        check("rst.result", 32'(r4), 32'd0);
        check("rst.lr16", 32'(lr16), 32'd1);
        check("rst.lr1", 32'(lr1), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        // Basic: [1,2,3,4].[5,6,7,8] = 70
        tx4(32'h04030201, 32'h08070605, 20'd70, 1'b0, "basic");
        release4("basic");

        // Stalled consumer then back-to-back
        tx4(32'h02020202, 32'h03030303, 20'd24, 1'b0, "stall");
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("stall.hold_result", 32'(r4), 32'd24);
            check("stall.hold_rv", 32'(rv4), 32'd1);
            check("stall.hold_lr", 32'(lr4), 32'd0);
        end
        release4("stall");
        tx4(32'h01000001, 32'h09090909, 20'd18, 1'b0, "b2b");
        release4("b2b");

        // Load during busy is ignored
        tx4(32'h04030201, 32'h08070605, 20'd70, 1'b1, "busy");
        release4("busy");

        // Reset mid-FEED at index 2
        @(negedge clock);
        a4 = 32'h04030201; b4 = 32'h08070605; lv4 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        lv4 = 1'b0;
        repeat (2) @(negedge clock);
        check("midrst.ma_before", 32'(ma4), 32'd3);
        reset = 1'b0;
        #1;
        check("midrst.lr", 32'(lr4), 32'd1);
        check("midrst.mrn", 32'(mrn4), 32'd0);
        check("midrst.ma", 32'(ma4), 32'd0);
        check("midrst.mb", 32'(mb4), 32'd0);
        check("midrst.rv", 32'(rv4), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tx4(32'h01010101, 32'h01010101, 20'd4, 1'b0, "postrst");
        release4("postrst");

        // N=16 maximum values
        @(negedge clock);
        a16 = '1; b16 = '1; lv16 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        lv16 = 1'b0;
        check("max.ma0", 32'(ma16), 32'd255);
        repeat (16) @(negedge clock);
        check("max.rv_early", 32'(rv16), 32'd0);
        check("max.ma_capture", 32'(ma16), 32'd0);
        check("max.mb_capture", 32'(mb16), 32'd0);
        @(negedge clock);
        check("max.rv", 32'(rv16), 32'd1);
        check("max.result", 32'(r16), 32'd1040400);
        check("max.ma_done", 32'(ma16), 32'd0);
        check("max.mb_done", 32'(mb16), 32'd0);
        rr16 = 1'b1;
        @(negedge clock);
        rr16 = 1'b0;
        check("max.rv_clr", 32'(rv16), 32'd0);
        check("max.lr_idle", 32'(lr16), 32'd1);

        // N=1 corner
        @(negedge clock);
        a1 = 8'd200; b1 = 8'd100; lv1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        lv1 = 1'b0;
        check("n1.ma0", 32'(ma1), 32'd200);
        @(negedge clock);
        check("n1.rv_early", 32'(rv1), 32'd0);
        @(negedge clock);
        check("n1.rv", 32'(rv1), 32'd1);
        check("n1.result", 32'(r1), 32'd20000);
        rr1 = 1'b1;
        @(negedge clock);
        rr1 = 1'b0;
        check("n1.lr_idle", 32'(lr1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
